// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, defaults and period helper for the PWM generator
package pwm_pkg;
  localparam int PWM_R_DEFAULT = 4;
  typedef logic [PWM_R_DEFAULT-1:0] duty_t;
  function automatic int pwm_period(input int r, input int prescale);
    return prescale * (1 << r);
  endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: one-clock tick every PRESCALE clocks (i_clk, i_rst async high -> o_tick)
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic tick;
  always_comb begin
    tick  = cnt_q == W'(PRESCALE - 1);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_tick = tick;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: R-bit PWM with double-buffered duty (i_clk, i_rst async high, i_w duty -> o_q, o_test_duty_count)
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int R        = PWM_R_DEFAULT,
  parameter int PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [R-1:0] i_w,
  output logic         o_q,
  output logic [R-1:0] o_test_duty_count
);
  logic         tick;
  logic [R-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic         q_q, q_d;
  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );
  // Duty is captured only on the wrapping tick; the output compares against
  // next-state values so it lines up with cnt/duty with no added latency.
  always_comb begin
    cnt_d  = tick ? cnt_q + R'(1) : cnt_q;
    duty_d = (tick && cnt_q == '1) ? i_w : duty_q;
    q_d    = cnt_d < duty_d;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      q_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      q_q    <= q_d;
    end
  assign o_q               = q_q;
  assign o_test_duty_count = cnt_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen at PRESCALE 1 and 3
module tb_pwm_gen;
  import pwm_pkg::*;
  localparam int P3 = 3;
  typedef struct {
    logic [3:0] w;
    int         highs;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic [3:0] w1, w3, c1, c3;
  logic       q1, q3;
  int         checks = 0, errors = 0;
  int         n1, n3, d1, d3;
  vec_t       tbl[8];
  always #5 clk = ~clk;
  pwm_gen #(.R(4), .PRESCALE(1)) u1 (
    .i_clk(clk), .i_rst(rst1), .i_w(w1), .o_q(q1), .o_test_duty_count(c1)
  );
  pwm_gen #(.R(4), .PRESCALE(P3)) u3 (
    .i_clk(clk), .i_rst(rst3), .i_w(w3), .o_q(q3), .o_test_duty_count(c3)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Reference: n clocks since reset release -> n/P ticks; the period counter is
  // ticks mod 16, and the duty in force is whatever i_w was at the edge where
  // the tick total last reached a multiple of 16.
  task automatic step();
    @(posedge clk);
    if (!rst1) begin
      n1++;
      if (n1 % 16 == 0) d1 = int'(w1);
    end
    if (!rst3) begin
      n3++;
      if (n3 % P3 == 0 && (n3 / P3) % 16 == 0) d3 = int'(w3);
    end
    #1;
    check("cnt1", 32'(c1), 32'(n1 % 16));
    check("q1", 32'(q1), 32'((n1 % 16) < d1));
    check("cnt3", 32'(c3), 32'((n3 / P3) % 16));
    check("q3", 32'(q3), 32'(((n3 / P3) % 16) < d3));
  endtask
  task automatic wait_wrap1();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (c1 !== 4'd0 && k < 40);
    check("wrap1", 32'(c1), 32'd0);
  endtask
  task automatic count_period1(output int h);
    h = int'(q1);
    repeat (15) begin
      step();
      h += int'(q1);
    end
  endtask
  task automatic wait_start3();
    int k;
    logic [3:0] prev;
    k = 0;
    do begin
      prev = c3;
      step();
      k++;
    end while (!(c3 == 4'd0 && prev == 4'd15) && k < 200);
    check("wrap3", 32'(c3 == 4'd0 && prev == 4'd15), 32'd1);
  endtask
  initial begin
    int h, len;
    tbl[0] = '{4'hF, 15};
    tbl[1] = '{4'hC, 12};
    tbl[2] = '{4'h8, 8};
    tbl[3] = '{4'h5, 5};
    tbl[4] = '{4'h3, 3};
    tbl[5] = '{4'h1, 1};
    tbl[6] = '{4'h0, 0};
    tbl[7] = '{4'hA, 10};
    rst1 = 1'b1; rst3 = 1'b1; w1 = 4'hF; w3 = 4'h5;
    n1 = 0; n3 = 0; d1 = 0; d3 = 0;
    #1;
    check("rst_q1", 32'(q1), 32'd0);
    check("rst_cnt1", 32'(c1), 32'd0);
    repeat (3) step();
    rst1 = 1'b0; rst3 = 1'b0;
    count_period1(h);
    check("first_period_hi", 32'(h), 32'd0);
    step();
    count_period1(h);
    check("full_f_hi", 32'(h), 32'd15);
    for (int i = 0; i < 8; i++) begin
      w1 = tbl[i].w;
      wait_wrap1();
      count_period1(h);
      check($sformatf("tbl%0d_hi", i), 32'(h), 32'(tbl[i].highs));
      repeat (18) step();
    end
    w1 = 4'h0;
    wait_wrap1();
    h = int'(q1);
    repeat (31) begin
      step();
      h += int'(q1);
    end
    check("zero_32_hi", 32'(h), 32'd0);
    w1 = 4'h4;
    wait_wrap1();
    h = int'(q1);
    repeat (5) begin
      step();
      h += int'(q1);
    end
    check("mid_cnt5", 32'(c1), 32'd5);
    w1 = 4'hC;
    repeat (10) begin
      step();
      h += int'(q1);
    end
    check("mid_keep4", 32'(h), 32'd4);
    step();
    count_period1(h);
    check("mid_next12", 32'(h), 32'd12);
    w1 = 4'hF;
    wait_wrap1();
    wait_wrap1();
    repeat (9) step();
    check("pre_arst_cnt", 32'(c1), 32'd9);
    check("pre_arst_q", 32'(q1), 32'd1);
    #2;
    rst1 = 1'b1;
    #1;
    check("arst_q", 32'(q1), 32'd0);
    check("arst_cnt", 32'(c1), 32'd0);
    n1 = 0; d1 = 0;
    repeat (2) step();
    rst1 = 1'b0;
    count_period1(h);
    check("post_arst_hi", 32'(h), 32'd0);
    wait_start3();
    h = int'(q3);
    len = 1;
    while (len < 200) begin
      step();
      if (c3 == 4'd0 && len > 3) break;
      h += int'(q3);
      len++;
    end
    check("p3_hi", 32'(h), 32'd15);
    check("p3_len", 32'(len), 32'(pwm_period(4, P3)));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) w1 = 4'($urandom);
      if ($urandom_range(15) == 0) w3 = 4'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
